// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: op encodings, FSM states and
// the helper that folds rotate amounts into one revolution.
package shift_pkg;

  localparam logic [2:0] OP_LSR = 3'b000;
  localparam logic [2:0] OP_ASR = 3'b001;
  localparam logic [2:0] OP_RR  = 3'b010;  // 011 also rotates right
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_ASL = 3'b101;
  localparam logic [2:0] OP_RL  = 3'b110;  // 111 also rotates left

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_rot(input logic [2:0] op);
    return ((op & 3'b110) == OP_RR) || ((op & 3'b110) == OP_RL);
  endfunction

  function automatic logic is_shl(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_ASL);
  endfunction

  // Rotations wrap every d_size positions (d_size is a power of two);
  // plain shifts keep the full amount so they saturate by iteration.
  function automatic logic [31:0] rot_amt(input logic [31:0]  amt,
                                          input logic [2:0]   op,
                                          input int unsigned  d_size);
    return is_rot(op) ? (amt & (d_size - 32'd1)) : amt;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between a requester (master) and the
// shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int D_SIZE = 4,
  parameter int A_SIZE = 4
);

  logic              req_valid_in;
  logic              req_ready_out;
  logic [D_SIZE-1:0] x_in;
  logic [A_SIZE-1:0] amt_in;
  logic [2:0]        op_in;
  logic              res_valid_out;
  logic              res_ready_in;
  logic [D_SIZE-1:0] y_out;
  logic              zf_out;
  logic              vf_out;
  logic              busy_out;

  modport master (
    output req_valid_in, x_in, amt_in, op_in, res_ready_in,
    input  req_ready_out, res_valid_out, y_out, zf_out, vf_out, busy_out
  );

  modport slave (
    input  req_valid_in, x_in, amt_in, op_in, res_ready_in,
    output req_ready_out, res_valid_out, y_out, zf_out, vf_out, busy_out
  );

endinterface

// File: rtl/barrelshifter.sv
// Combinational single-pass shifter: shifts or rotates x by 0..D_SIZE-1.
// zf/cf describe this one pass only.
module barrelshifter
  import shift_pkg::*;
#(
  parameter int D_SIZE = 4
) (
  input  logic [D_SIZE-1:0]         x,
  input  logic [$clog2(D_SIZE)-1:0] amt,
  input  logic [2:0]                op,
  output logic [D_SIZE-1:0]         y,
  output logic                      zf,
  output logic                      cf
);

  localparam int S_W = $clog2(D_SIZE);

  logic [S_W-1:0]    neg_amt;
  logic [D_SIZE-1:0] fill;
  logic [D_SIZE-1:0] rotr;
  logic [D_SIZE-1:0] rotl;
  logic [D_SIZE-1:0] asr;

  always_comb begin
    // D_SIZE - amt, wrapped to S_W bits; amt = 0 gives 0 so rotates stay x
    neg_amt = S_W'(D_SIZE) - amt;
    rotr    = (x >> amt) | (x << neg_amt);
    rotl    = (x << amt) | (x >> neg_amt);
    asr     = D_SIZE'($signed(x) >>> amt);
    fill    = {D_SIZE{x[0]}} & ~({D_SIZE{1'b1}} << amt);

    case (op)
      OP_LSR:  y = x >> amt;
      OP_ASR:  y = asr;
      OP_LSL:  y = x << amt;
      OP_ASL:  y = (x << amt) | fill;
      default: y = op[2] ? rotl : rotr;
    endcase

    zf = (y == '0);
    if (amt == '0) begin
      cf = 1'b0;
    end else if (op[2]) begin
      cf = x[neg_amt];
    end else begin
      cf = x[amt - S_W'(1)];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request, iterates passes of at most
// D_SIZE-1 positions through a single barrel shifter, then holds the result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int D_SIZE = 4,
  parameter int A_SIZE = 4
) (
  input logic          clk_in,
  input logic          rst_n_in,
  shift_sequencer_if.slave bus
);

  localparam int S_W      = $clog2(D_SIZE);
  localparam int STEP_MAX = D_SIZE - 1;

  state_t            state_reg, state_next;
  logic [D_SIZE-1:0] acc_reg, acc_next;
  logic [A_SIZE-1:0] rem_reg, rem_next;
  logic [2:0]        op_reg, op_next;
  logic              vf_reg, vf_next;
  logic              live_reg;

  logic [S_W-1:0]    step;
  logic [D_SIZE-1:0] shifted;
  logic [1:0]        bs_flags_unused;
  logic [A_SIZE-1:0] eff_amt;
  logic              ready;
  logic              accept;
  logic              done;

  barrelshifter #(
    .D_SIZE (D_SIZE)
  ) u_barrel (
    .x   (acc_reg),
    .amt (step),
    .op  (op_reg),
    .y   (shifted),
    .zf  (bs_flags_unused[0]),
    .cf  (bs_flags_unused[1])
  );

  // live_reg keeps ready low through reset and rises on the first clean edge
  assign ready   = live_reg && (state_reg == IDLE);
  assign accept  = bus.req_valid_in && ready;
  assign done    = (state_reg == DONE);
  assign eff_amt = A_SIZE'(rot_amt(32'(bus.amt_in), bus.op_in, D_SIZE));

  always_comb begin
    if (32'(rem_reg) > 32'(STEP_MAX)) begin
      step = S_W'(STEP_MAX);
    end else begin
      step = S_W'(rem_reg);
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    op_next    = op_reg;
    vf_next    = vf_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          acc_next   = bus.x_in;
          op_next    = bus.op_in;
          rem_next   = eff_amt;
          vf_next    = 1'b0;
          state_next = (eff_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_next = shifted;
        rem_next = rem_reg - A_SIZE'(step);
        if (is_shl(op_reg) && (shifted[D_SIZE-1] != acc_reg[D_SIZE-1])) begin
          vf_next = 1'b1;
        end
        if (rem_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
      op_reg    <= '0;
      vf_reg    <= 1'b0;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      op_reg    <= op_next;
      vf_reg    <= vf_next;
      live_reg  <= 1'b1;
    end
  end

  // Result comes straight from acc/vf registers, gated to zero outside DONE
  assign bus.req_ready_out = ready;
  assign bus.res_valid_out = done;
  assign bus.busy_out      = (state_reg != IDLE);
  assign bus.y_out         = done ? acc_reg : '0;
  assign bus.zf_out        = done && (acc_reg == '0);
  assign bus.vf_out        = done && vf_reg;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter D_SIZE, default 4: data width; power of two, at least 4.
REQ-002 SHALL have parameter A_SIZE, default 4: request shift-amount width; amounts 0..2^A_SIZE-1.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_in, input, 1 bit: a request is present.
REQ-006 SHALL have port req_ready_out, output, 1 bit: the block accepts a request.
REQ-007 SHALL have port x_in, input, D_SIZE bits: operand.
REQ-008 SHALL have port amt_in, input, A_SIZE bits: total shift amount.
REQ-009 SHALL have port op_in, input, 3 bits: 000 LSR, 001 ASR, 01x RR, 100 LSL, 101 ASL (vacated bits filled with bit 0), 11x RL.
REQ-010 SHALL have port res_valid_out, output, 1 bit: result is valid.
REQ-011 SHALL have port res_ready_in, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port y_out, output, D_SIZE bits: result.
REQ-013 SHALL have port zf_out, output, 1 bit: zero flag.
REQ-014 SHALL have port vf_out, output, 1 bit: overflow flag.
REQ-015 SHALL have port busy_out, output, 1 bit: high in states SHIFT and DONE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL drive req_ready_out high only in IDLE.
REQ-018 SHALL accept a request on a rising edge where req_valid_in and req_ready_out are both high, latching x_in into acc, op_in into op and the effective amount into rem.
REQ-019 SHALL set the effective amount to amt_in mod D_SIZE for RR/RL, and to amt_in for all other ops.
REQ-020 SHALL, on accept, go to DONE if the effective amount is 0 (y = x, no pass); otherwise go to SHIFT.
REQ-021 SHALL, in SHIFT, perform one pass per edge: step = min(rem, D_SIZE-1); acc <= barrel-shift(acc, step, op); rem <= rem - step; go to DONE when the new rem is 0.
REQ-022 SHALL produce the result ceil(eff/(D_SIZE-1)) edges after the accept edge, or 1 edge after it when eff = 0.
REQ-023 SHALL, for LSL/LSR with amt >= D_SIZE, produce 0, and for ASR produce the sign fill; both follow naturally from iteration.
REQ-024 SHALL, in DONE, hold res_valid_out=1 and keep y_out, zf_out and vf_out stable until res_ready_in=1; on that edge go to IDLE.
REQ-025 SHALL not allow the same-edge bypass DONE->accept: a new request is accepted no earlier than the edge after the result is consumed.
REQ-026 SHALL set zf_out = (y_out == 0).
REQ-027 SHALL, for LSL/ASL, set vf_out sticky whenever any pass changes acc[D_SIZE-1] relative to its value before that pass; vf_out SHALL be 0 for all other ops.
REQ-028 SHALL ignore req_valid_in and input changes while busy; all request values come from the latched copies.
REQ-029 SHALL make y_out, zf_out and vf_out registered, valid only when res_valid_out=1, and 0 in IDLE.

Reset
REQ-030 SHALL, when rst_n_in=0 at any time including mid-SHIFT, immediately force state IDLE, acc, rem, op and vf to 0, res_valid_out=0, busy_out=0 and req_ready_out=0.
REQ-031 SHALL hold req_ready_out=0 while reset is asserted and raise it to 1 on the first edge after deassertion; an in-flight request is discarded with no result produced.

Structure
REQ-032 SHALL place in shared package shift_pkg: the op encodings as constants, the state enum (IDLE/SHIFT/DONE), and helper function rot_amt.
REQ-033 SHALL instantiate the existing combinational barrelshifter #(D_SIZE) once as its only sub-module, fed by acc, step and op; the flags of that sub-module SHALL be unused.
REQ-034 SHALL keep the datapath to one acc register, one rem counter and one flag register; no FIFO.

Verification (D_SIZE=4, A_SIZE=4)
REQ-035 SHALL verify: ASR x=1000, amt=2 -> 1 pass, y=1110, zf=0, vf=0, res_valid 1 edge after accept.
REQ-036 SHALL verify: LSL x=0011, amt=5 -> passes of 3 and 2, y=0000, zf=1, vf=1, valid 2 edges after accept.
REQ-037 SHALL verify: RR x=1001, amt=6 -> eff 2, y=0110, 1 pass; RL x=1011, amt=4 -> eff 0, y=1011, no pass.
REQ-038 SHALL verify: res_ready_in held low 5 cycles with a new req_valid_in asserted -> y stable, req_ready_out=0, second request accepted only after consumption.
REQ-039 SHALL verify: rst_n_in pulsed low mid-SHIFT of LSR amt=15 -> immediate IDLE, outputs 0, no res_valid_out, next request runs correctly.
REQ-040 SHALL verify: ASL x=0001, amt=1 -> y=0011, vf=0; back-to-back requests with res_ready_in=1 -> one result per request, in order.
